// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt controller: register byte offsets
// on the core bus and the default debounce divider width.
// No logic, no latency, no flow control.
package gpio_pkg;

    localparam int GPIO_BUS_W     = 32;
    localparam int GPIO_DIV_W_DEF = 16;

    localparam logic [7:0] GPIO_DATA_OFS   = 8'h00;
    localparam logic [7:0] GPIO_DIR_OFS    = 8'h04;
    localparam logic [7:0] GPIO_READ_OFS   = 8'h08;
    localparam logic [7:0] GPIO_SET_OFS    = 8'h0C;
    localparam logic [7:0] GPIO_CLR_OFS    = 8'h10;
    localparam logic [7:0] GPIO_TGL_OFS    = 8'h14;
    localparam logic [7:0] GPIO_IRQ_EN_OFS = 8'h18;
    localparam logic [7:0] GPIO_RISE_OFS   = 8'h1C;
    localparam logic [7:0] GPIO_FALL_OFS   = 8'h20;
    localparam logic [7:0] GPIO_STAT_OFS   = 8'h24;
    localparam logic [7:0] GPIO_DEB_OFS    = 8'h28;

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning: two-flop synchroniser, then an optional debounce that
// only accepts a new level after two consecutive agreeing prescaler ticks.
// Latency: 2 cycles to `filtered` with deb_div = 0; no backpressure.
// Ports: clk/rst (sync, active high), gpio_in (async pins), deb_div (divider
// value N, 0 = bypass), div_wr (restart prescaler), filtered (clean levels).
module gpio_in_filter #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [DIV_W-1:0] deb_div,
    input  logic             div_wr,
    output logic [WIDTH-1:0] filtered
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] samp_q,  samp_d;
    logic [WIDTH-1:0] filt_q,  filt_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;

    logic             bypass;
    logic             tick;
    logic [WIDTH-1:0] agree;

    always_comb begin
        sync1_d = gpio_in;
        sync2_d = sync1_q;

        bypass = (deb_div == '0);
        // Prescaler runs 0..N and ticks on N.
        tick   = !bypass && (cnt_q == deb_div);

        cnt_d = cnt_q + DIV_W'(1);
        if (div_wr || bypass || tick) begin
            cnt_d = '0;
        end

        // A bit only moves when this tick's sample matches the last one.
        agree  = ~(sync2_q ^ samp_q);
        samp_d = samp_q;
        filt_d = filt_q;
        if (bypass) begin
            // Track the live level so enabling debounce starts from the
            // current pin state rather than a stale one.
            samp_d = sync2_q;
            filt_d = sync2_q;
        end else if (tick) begin
            samp_d = sync2_q;
            filt_d = (agree & sync2_q) | (~agree & filt_q);
        end

        filtered = bypass ? sync2_q : filt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO block: data/direction registers with atomic set/clear/
// toggle, filtered inputs, per-pin edge capture into W1C status and one irq.
// Latency: 1-cycle bus ack; master holding valid is accepted every 2 cycles.
// Ports: clk/rst, bus_valid/we/addr/wdata in, bus_rdata/bus_ready out,
// gpio_in pins, gpio_out (DATA & DIR), gpio_oe (DIR), irq (registered).
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV_W = GPIO_DIV_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [GPIO_BUS_W-1:0] bus_addr,
    input  logic [GPIO_BUS_W-1:0] bus_wdata,
    output logic [GPIO_BUS_W-1:0] bus_rdata,
    output logic                  bus_ready,
    input  logic [WIDTH-1:0]      gpio_in,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_oe,
    output logic                  irq
);

    logic [WIDTH-1:0]      data_q,    data_d;
    logic [WIDTH-1:0]      dir_q,     dir_d;
    logic [WIDTH-1:0]      irq_en_q,  irq_en_d;
    logic [WIDTH-1:0]      rise_en_q, rise_en_d;
    logic [WIDTH-1:0]      fall_en_q, fall_en_d;
    logic [WIDTH-1:0]      stat_q,    stat_d;
    logic [WIDTH-1:0]      prev_q,    prev_d;
    logic [DIV_W-1:0]      deb_div_q, deb_div_d;
    logic [GPIO_BUS_W-1:0] rdata_q,   rdata_d;
    logic                  ready_q,   ready_d;
    logic                  irq_q,     irq_d;

    logic                  accept;
    logic                  wr;
    logic [7:0]            ofs;
    logic [WIDTH-1:0]      wdat;
    logic [WIDTH-1:0]      w1c;
    logic [WIDTH-1:0]      evt;
    logic [GPIO_BUS_W-1:0] rd_val;
    logic                  div_wr;
    logic [WIDTH-1:0]      filtered;
    logic                  unused_bus_bits;

    // Upper address bits and unused write-data bits are don't-care.
    assign unused_bus_bits = ^{bus_addr, bus_wdata};

    gpio_in_filter #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .gpio_in  (gpio_in),
        .deb_div  (deb_div_q),
        .div_wr   (div_wr),
        .filtered (filtered)
    );

    always_comb begin
        // The one-cycle ack blocks a second accept of the same held request.
        accept = bus_valid && !ready_q;
        wr     = accept && bus_we;
        ofs    = bus_addr[7:0];
        wdat   = bus_wdata[WIDTH-1:0];
        div_wr = wr && (ofs == GPIO_DEB_OFS);

        data_d    = data_q;
        dir_d     = dir_q;
        irq_en_d  = irq_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        deb_div_d = deb_div_q;
        w1c       = '0;

        if (wr) begin
            case (ofs)
                GPIO_DATA_OFS:   data_d    = wdat;
                GPIO_DIR_OFS:    dir_d     = wdat;
                GPIO_SET_OFS:    data_d    = data_q | wdat;
                GPIO_CLR_OFS:    data_d    = data_q & ~wdat;
                GPIO_TGL_OFS:    data_d    = data_q ^ wdat;
                GPIO_IRQ_EN_OFS: irq_en_d  = wdat;
                GPIO_RISE_OFS:   rise_en_d = wdat;
                GPIO_FALL_OFS:   fall_en_d = wdat;
                GPIO_STAT_OFS:   w1c       = wdat;
                GPIO_DEB_OFS:    deb_div_d = bus_wdata[DIV_W-1:0];
                default:         ;
            endcase
        end

        // Edges on output pins are masked so a DIR flip cannot fake one.
        evt = ((filtered & ~prev_q & rise_en_q) |
               (~filtered & prev_q & fall_en_q)) & ~dir_q;
        // Clear first, then set: a coincident edge keeps the bit high.
        stat_d = (stat_q & ~w1c) | evt;
        prev_d = filtered;
        irq_d  = |(stat_q & irq_en_q);

        rd_val = '0;
        case (ofs)
            GPIO_DATA_OFS:   rd_val[WIDTH-1:0] = data_q;
            GPIO_DIR_OFS:    rd_val[WIDTH-1:0] = dir_q;
            GPIO_READ_OFS:   rd_val[WIDTH-1:0] = (dir_q & data_q) |
                                                 (~dir_q & filtered);
            GPIO_IRQ_EN_OFS: rd_val[WIDTH-1:0] = irq_en_q;
            GPIO_RISE_OFS:   rd_val[WIDTH-1:0] = rise_en_q;
            GPIO_FALL_OFS:   rd_val[WIDTH-1:0] = fall_en_q;
            GPIO_STAT_OFS:   rd_val[WIDTH-1:0] = stat_q;
            GPIO_DEB_OFS:    rd_val[DIV_W-1:0] = deb_div_q;
            default:         ;
        endcase

        // Writes also return the register's pre-write contents.
        rdata_d = accept ? rd_val : rdata_q;
        ready_d = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            dir_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            prev_q    <= '0;
            deb_div_q <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            dir_q     <= dir_d;
            irq_en_q  <= irq_en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            prev_q    <= prev_d;
            deb_div_q <= deb_div_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            irq_q     <= irq_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign gpio_out  = data_q & dir_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
module tb_gpio_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_valid = 1'b0;
    logic        bus_valid8 = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] rdata, rdata8;
    logic        ready, ready8;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out, gpio_oe;
    logic [7:0]  gpio_in8 = '0;
    logic [7:0]  gpio_out8, gpio_oe8;
    logic        irq, irq8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_irq_ctrl #(.WIDTH(32), .DIV_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata),
        .bus_ready(ready), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_irq_ctrl #(.WIDTH(8), .DIV_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .bus_valid(bus_valid8), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata8),
        .bus_ready(ready8), .gpio_in(gpio_in8), .gpio_out(gpio_out8),
        .gpio_oe(gpio_oe8), .irq(irq8)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] gin;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [7:0] addr, logic [31:0] wd,
                                logic [31:0] gin, logic [31:0] exp_rd,
                                logic [31:0] exp_out, logic [31:0] exp_oe);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.gin = gin;
        v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oe = exp_oe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus transaction: accept edge, sample response, let ready drop.
    task automatic xfer(input logic sel8, input logic we, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic irq_at);
        bus_we    = we;
        bus_addr  = {24'h0, a};
        bus_wdata = wd;
        if (sel8) bus_valid8 = 1'b1;
        else      bus_valid  = 1'b1;
        @(posedge clk); #1;
        bus_valid  = 1'b0;
        bus_valid8 = 1'b0;
        chk("bus_ready", {31'b0, sel8 ? ready8 : ready}, 32'h1);
        rd     = sel8 ? rdata8 : rdata;
        irq_at = irq;
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'b0, sel8 ? ready8 : ready}, 32'h0);
    endtask

    task automatic rd_chk(input string nm, input logic sel8,
                          input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        i;
        xfer(sel8, 1'b0, a, 32'h0, r, i);
        chk(nm, r, exp);
    endtask

    task automatic wr_chk(input string nm, input logic sel8, input logic [7:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_old);
        logic [31:0] r;
        logic        i;
        xfer(sel8, 1'b1, a, wd, r, i);
        chk(nm, r, exp_old);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        i;

        // Reset reads of every mapped offset, then the unmapped 0x30.
        for (int a = 0; a <= 'h28; a += 4)
            vecs.push_back(mk(0, 8'(a), 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h30, 0, 0, 0, 0, 0));
        // Direction / data / READ mixing.
        vecs.push_back(mk(1, 8'h04, 32'h0000FFFF, 32'hFFFF0000, 0, 0, 32'hFFFF));
        vecs.push_back(mk(1, 8'h00, 32'hA5A55A5A, 32'hFFFF0000, 0, 32'h5A5A, 32'hFFFF));
        vecs.push_back(mk(0, 8'h08, 0, 32'hFFFF0000, 32'hFFFF5A5A, 32'h5A5A, 32'hFFFF));
        vecs.push_back(mk(0, 8'h00, 0, 32'hFFFF0000, 32'hA5A55A5A, 32'h5A5A, 32'hFFFF));
        // Atomic set / clear / toggle.
        vecs.push_back(mk(1, 8'h00, 32'h0F0F, 32'hFFFF0000, 32'hA5A55A5A, 32'h0F0F, 32'hFFFF));
        vecs.push_back(mk(1, 8'h0C, 32'hF000, 32'hFFFF0000, 0, 32'hFF0F, 32'hFFFF));
        vecs.push_back(mk(1, 8'h10, 32'h000F, 32'hFFFF0000, 0, 32'hFF00, 32'hFFFF));
        vecs.push_back(mk(1, 8'h14, 32'hFFFF, 32'hFFFF0000, 0, 32'h00FF, 32'hFFFF));
        vecs.push_back(mk(0, 8'h00, 0, 32'hFFFF0000, 32'h000000FF, 32'h00FF, 32'hFFFF));
        vecs.push_back(mk(0, 8'h0C, 0, 32'hFFFF0000, 0, 32'h00FF, 32'hFFFF));
        // Unmapped write ignored.
        vecs.push_back(mk(1, 8'h30, 32'hFFFFFFFF, 32'hFFFF0000, 0, 32'h00FF, 32'hFFFF));
        vecs.push_back(mk(0, 8'h00, 0, 32'hFFFF0000, 32'h000000FF, 32'h00FF, 32'hFFFF));
        // DEB_DIV truncates to 16 bits.
        vecs.push_back(mk(1, 8'h28, 32'h00012345, 32'hFFFF0000, 0, 32'h00FF, 32'hFFFF));
        vecs.push_back(mk(0, 8'h28, 0, 32'hFFFF0000, 32'h2345, 32'h00FF, 32'hFFFF));
        vecs.push_back(mk(1, 8'h28, 0, 32'hFFFF0000, 32'h2345, 32'h00FF, 32'hFFFF));
        // All inputs: READ shows pins directly.
        vecs.push_back(mk(1, 8'h04, 0, 32'hFFFF0000, 32'hFFFF, 0, 0));
        vecs.push_back(mk(0, 8'h08, 0, 32'hFFFF0000, 32'hFFFF0000, 0, 0));
        vecs.push_back(mk(0, 8'h24, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h24, 0, 32'h0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset bus_ready", {31'b0, ready}, 0);
        chk("reset bus_rdata", rdata, 0);
        chk("reset gpio_out", gpio_out, 0);
        chk("reset irq", {31'b0, irq}, 0);

        foreach (vecs[n]) begin
            gpio_in = vecs[n].gin;
            xfer(1'b0, vecs[n].we, vecs[n].addr, vecs[n].wdata, r, i);
            chk($sformatf("vec%0d rdata", n), r, vecs[n].exp_rd);
            chk($sformatf("vec%0d gpio_out", n), gpio_out, vecs[n].exp_out);
            chk($sformatf("vec%0d gpio_oe", n), gpio_oe, vecs[n].exp_oe);
        end

        // Rising edge on pin 0 -> irq exactly three edges after sampling.
        wr_chk("rise_en wr", 0, 8'h1C, 32'h1, 0);
        wr_chk("irq_en wr", 0, 8'h18, 32'h1, 0);
        chk("irq idle", {31'b0, irq}, 0);
        gpio_in = 32'h1;
        repeat (3) @(posedge clk);
        #1 chk("irq before e+3", {31'b0, irq}, 0);
        @(posedge clk);
        #1 chk("irq at e+3", {31'b0, irq}, 1);
        rd_chk("stat after rise", 0, 8'h24, 32'h1);
        xfer(1'b0, 1'b1, 8'h24, 32'h1, r, i);
        chk("w1c old value", r, 32'h1);
        chk("irq still high at ack", {31'b0, i}, 1);
        chk("irq cleared k+1", {31'b0, irq}, 0);
        rd_chk("stat cleared", 0, 8'h24, 0);

        // Falling edge, then a rise landing on the same edge as a W1C.
        wr_chk("fall_en wr", 0, 8'h20, 32'h1, 0);
        gpio_in = 32'h0;
        repeat (4) @(posedge clk);
        #1 rd_chk("stat after fall", 0, 8'h24, 32'h1);
        gpio_in = 32'h1;
        repeat (2) @(posedge clk);
        #1 wr_chk("w1c vs edge old", 0, 8'h24, 32'h1, 32'h1);
        rd_chk("stat set wins", 0, 8'h24, 32'h1);
        chk("irq with stat", {31'b0, irq}, 1);

        // Disabling the interrupt leaves status untouched.
        wr_chk("irq_en off", 0, 8'h18, 32'h0, 32'h1);
        chk("irq off via en", {31'b0, irq}, 0);
        rd_chk("stat kept", 0, 8'h24, 32'h1);
        wr_chk("stat clear", 0, 8'h24, 32'h1, 32'h1);

        // Output pins never capture edges, and DIR flips alone do nothing.
        wr_chk("dir pin0 out", 0, 8'h04, 32'h1, 0);
        gpio_in = 32'h0;
        repeat (4) @(posedge clk);
        #1 wr_chk("dir pin0 in", 0, 8'h04, 32'h0, 32'h1);
        repeat (4) @(posedge clk);
        #1 rd_chk("stat masked", 0, 8'h24, 0);

        // Debounce N=3: ticks every 4 edges after the DEB_DIV write.
        wr_chk("rise_en pin1", 0, 8'h1C, 32'h2, 32'h1);
        wr_chk("deb_div 3", 0, 8'h28, 32'h3, 0);
        repeat (5) @(posedge clk);
        #1 gpio_in = 32'h2;
        repeat (5) @(posedge clk);
        #1 gpio_in = 32'h0;
        repeat (12) @(posedge clk);
        #1 rd_chk("short pulse READ", 0, 8'h08, 0);
        rd_chk("short pulse stat", 0, 8'h24, 0);
        gpio_in = 32'h2;
        repeat (12) @(posedge clk);
        #1 rd_chk("long pulse READ", 0, 8'h08, 32'h2);
        rd_chk("long pulse stat", 0, 8'h24, 32'h2);

        // Narrow build: registers are 8 bits wide, zero-extended.
        wr_chk("w8 data", 1, 8'h00, 32'hFFFFFFFF, 0);
        wr_chk("w8 dir", 1, 8'h04, 32'hFFFFFFFF, 0);
        rd_chk("w8 data rd", 1, 8'h00, 32'h000000FF);
        rd_chk("w8 dir rd", 1, 8'h04, 32'h000000FF);
        rd_chk("w8 unmapped", 1, 8'h30, 0);
        chk("w8 gpio_out", {24'h0, gpio_out8}, 32'hFF);

        // Reset while a response is on the bus drops it.
        bus_we    = 1'b0;
        bus_addr  = 32'h28;
        bus_valid = 1'b1;
        @(posedge clk);
        #1 bus_valid = 1'b0;
        chk("pre-reset ready", {31'b0, ready}, 1);
        chk("pre-reset rdata", rdata, 32'h3);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("reset drops ready", {31'b0, ready}, 0);
        chk("reset clears rdata", rdata, 0);
        rst = 1'b0;
        rd_chk("deb_div after reset", 0, 8'h28, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
